// File: rtl/aes_inv_key_sched_if.sv
// Stream and S-box port bundle for the reverse AES-128 key schedule.
// slave: the key-schedule block; master: the consumer/controller side.
interface aes_inv_key_sched_if;
    logic         start_in;
    logic [127:0] key_last_in;
    logic         rk_ready_in;
    logic         rk_valid_out;
    logic [127:0] rk_out;
    logic [3:0]   rk_round_out;
    logic         busy_out;
    logic         done_out;
    logic [31:0]  sbox_word_out;
    logic [31:0]  sbox_word_in;

    modport slave (
        input  start_in, key_last_in, rk_ready_in, sbox_word_in,
        output rk_valid_out, rk_out, rk_round_out, busy_out, done_out, sbox_word_out
    );

    modport master (
        output start_in, key_last_in, rk_ready_in, sbox_word_in,
        input  rk_valid_out, rk_out, rk_round_out, busy_out, done_out, sbox_word_out
    );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: starting from the round-NR key, emits
// round keys NR..0 one per handshake, deriving each previous key with the
// inverse recurrence. SubWord is served by an external combinational S-box bank.
module aes_inv_key_sched #(
    parameter int unsigned NR = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_key_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [7:0]   rcon;

    // Previous-key recurrence; the S-box request depends only on key_q,
    // so there is no combinational path from sbox_word_in back to the request.
    always_comb begin
        w0 = key_q[127:96];
        w1 = key_q[95:64];
        w2 = key_q[63:32];
        w3 = key_q[31:0];
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        unique case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        p0 = w0 ^ bus.sbox_word_in ^ {rcon, 24'h0};
    end

    assign bus.sbox_word_out = {p3[23:0], p3[31:24]};
    assign bus.rk_valid_out  = (state_q == EMIT);
    assign bus.rk_out        = key_q;
    assign bus.rk_round_out  = round_q;
    assign bus.busy_out      = (state_q == EMIT);
    assign bus.done_out      = (state_q == FIN);

    // Next-state, key and round update.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    key_d   = bus.key_last_in;
                    round_d = 4'(NR);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.rk_ready_in) begin
                    if (round_q != 4'd0) begin
                        key_d   = {p0, p1, p2, p3};
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, key and round registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched. Expected keys come from a
// forward AES-128 key expansion, replayed in reverse round order.
module tb_aes_inv_key_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_inv_key_sched_if bus();

    aes_inv_key_sched #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [7:0]   sbox [256];
    logic         tbl_ready = 1'b0;
    logic [127:0] mk [2][11];

    typedef struct packed {
        logic [3:0]   r;
        logic [127:0] k;
    } exp_t;
    exp_t expq[$];
    logic pend_done = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // External S-box bank: same-cycle combinational return.
    always_comb begin
        bus.sbox_word_in = tbl_ready ? {sbox[bus.sbox_word_out[31:24]], sbox[bus.sbox_word_out[23:16]],
                                        sbox[bus.sbox_word_out[15:8]],  sbox[bus.sbox_word_out[7:0]]} : '0;
    end

    task automatic build_sbox();
        logic [7:0] inv, x8;
        for (int x = 0; x < 256; x++) begin
            x8 = 8'(x);
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward FIPS-197 key expansion of a cipher key into mk[idx][0..10].
    task automatic expand(input int idx, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            mk[idx][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_exp(input int idx);
        for (int r = 10; r >= 0; r--)
            expq.push_back({4'(r), mk[idx][r]});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, {127'b0, bus.rk_valid_out}, '0);
        chk({tag, "_busy"},  {127'b0, bus.busy_out}, '0);
        chk({tag, "_done"},  {127'b0, bus.done_out}, '0);
        chk({tag, "_rk"},    bus.rk_out, '0);
        chk({tag, "_round"}, {124'b0, bus.rk_round_out}, '0);
        chk({tag, "_sbox"},  {96'b0, bus.sbox_word_out}, '0);
    endtask

    // Compare process: checks the stream against the expected queue every cycle.
    always @(negedge clk) begin
        if (rst_n && tbl_ready) begin
            if (pend_done) begin
                chk("done_pulse", {127'b0, bus.done_out}, 128'd1);
                chk("fin_valid",  {127'b0, bus.rk_valid_out}, '0);
                chk("fin_busy",   {127'b0, bus.busy_out}, '0);
                pend_done = 1'b0;
                done_cnt++;
            end else begin
                chk("done_low", {127'b0, bus.done_out}, '0);
            end
            if (bus.rk_valid_out) begin
                chk("busy_in_emit", {127'b0, bus.busy_out}, 128'd1);
                if (expq.size() == 0) begin
                    chk("unexpected_key", {127'b0, bus.rk_valid_out}, '0);
                end else begin
                    chk("rk", bus.rk_out, expq[0].k);
                    chk("rk_round", {124'b0, bus.rk_round_out}, {124'b0, expq[0].r});
                    if (bus.rk_ready_in) begin
                        void'(expq.pop_front());
                        if (expq.size() == 0) pend_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int low5;
        bit did5;

        bus.start_in = 1'b0;
        bus.key_last_in = '0;
        bus.rk_ready_in = 1'b0;

        build_sbox();
        tbl_ready = 1'b1;
        expand(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        expand(1, 128'h0);

        // Literal pins on the model itself.
        chk("pin_sbox_word", {96'b0, subw(32'h5c006e57)}, {96'b0, 32'h4a639f5b});
        chk("pin_k10", mk[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("pin_k9",  mk[0][9],  128'hac7766f319fadc2128d12941575c006e);
        chk("pin_k1",  mk[0][1],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("pin_zero_k10", mk[1][10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Reset state.
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;

        // Run 1: full throughput, start pulses during EMIT must be ignored.
        @(posedge clk); #1;
        push_exp(0);
        bus.key_last_in = mk[0][10];
        bus.start_in = 1'b1;
        bus.rk_ready_in = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            bus.start_in = (n == 3 || n == 7);
            bus.key_last_in = (n == 3 || n == 7) ? mk[1][10] : mk[0][10];
            if (n == 1) begin
                chk("sbox_req_first", {96'b0, bus.sbox_word_out}, {96'b0, 32'h5c006e57});
                chk("sbox_ret_first", {96'b0, bus.sbox_word_in}, {96'b0, 32'h4a639f5b});
            end
            if (bus.done_out) break;
        end
        bus.start_in = 1'b0;
        chk("run1_latency", 128'(n), 128'd12);

        // Run 2: random backpressure with a 5-cycle stall at round 5;
        // start on the FIN cycle is ignored, then back-to-back start in IDLE.
        @(posedge clk); #1;
        push_exp(0);
        bus.key_last_in = mk[0][10];
        bus.start_in = 1'b1;
        bus.rk_ready_in = 1'b0;
        low5 = 0; did5 = 1'b0; n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            bus.start_in = 1'b0;
            if (bus.done_out) break;
            if (low5 > 0) begin
                bus.rk_ready_in = 1'b0;
                low5--;
            end else if (bus.rk_valid_out && bus.rk_round_out == 4'd5 && !did5) begin
                did5 = 1'b1;
                low5 = 4;
                bus.rk_ready_in = 1'b0;
            end else begin
                bus.rk_ready_in = 1'($urandom_range(0, 1));
            end
        end
        chk("run2_finished", {127'b0, bus.done_out}, 128'd1);
        chk("run2_stall5_seen", {127'b0, did5}, 128'd1);
        bus.start_in = 1'b1;
        bus.key_last_in = ~mk[0][10];
        @(posedge clk); #1;
        push_exp(1);
        bus.key_last_in = mk[1][10];
        bus.start_in = 1'b1;
        bus.rk_ready_in = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            bus.start_in = 1'b0;
            if (bus.done_out) break;
        end
        chk("zero_run_latency", 128'(n), 128'd12);

        // Run 3: asynchronous reset in the middle of EMIT.
        @(posedge clk); #1;
        push_exp(0);
        bus.key_last_in = mk[0][10];
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        expq.delete();
        pend_done = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("post_reset_valid", {127'b0, bus.rk_valid_out}, '0);
            chk("post_reset_busy",  {127'b0, bus.busy_out}, '0);
        end

        // Run 4: fresh start after the abort reloads from scratch.
        push_exp(0);
        bus.key_last_in = mk[0][10];
        bus.start_in = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            bus.start_in = 1'b0;
            if (bus.done_out) break;
        end
        chk("run4_latency", 128'(n), 128'd12);

        @(posedge clk); #1;
        repeat (2) @(negedge clk);
        chk("queue_drained", 128'(expq.size()), '0);
        chk("done_count", 128'(done_cnt), 128'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
